// File: rtl/arb_pkg.sv
// Shared definitions for the 4-channel arbiter.
//   N_REQ        : number of requesters
//   ID_W         : width of a requester index
//   HOLD_W       : width of the hold counter
//   MAX_HOLD_DEF : default grant hold limit, in cycles
//   state_e      : arbiter FSM states
//   onehot()     : index to one-hot grant vector
package arb_pkg;
  localparam int N_REQ        = 4;
  localparam int ID_W         = 2;
  localparam int HOLD_W       = 8;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    return N_REQ'(1) << id;
  endfunction
endpackage

// File: rtl/arb_rr_4ch_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   mode        : 0 = fixed priority, 1 = round-robin
//   req         : request vector, one bit per requester
//   grant       : one-hot grant, zero when idle
//   grant_id    : index of the granted requester
//   grant_valid : a grant is live
//   timeout     : one-cycle pulse on forced revocation
// master = requester side, slave = arbiter side.
interface arb_rr_4ch_if;
  import arb_pkg::*;
  logic             mode;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_valid;
  logic             timeout;

  modport master (output mode, req, input grant, grant_id, grant_valid, timeout);
  modport slave  (input mode, req, output grant, grant_id, grant_valid, timeout);
endinterface

// File: rtl/priority_encoder_4to2.sv
// 4-to-2 priority encoder. The highest set bit wins.
//   i_req   : request vector
//   o_idx   : index of the highest set bit. 0 when i_req is zero.
//   o_valid : i_req has at least one bit set
module priority_encoder_4to2 (
  input  logic [3:0] i_req,
  output logic [1:0] o_idx,
  output logic       o_valid
);
  always_comb begin
    o_idx   = 2'd0;
    o_valid = |i_req;
    casez (i_req)
      4'b1???: o_idx = 2'd3;
      4'b01??: o_idx = 2'd2;
      4'b001?: o_idx = 2'd1;
      default: o_idx = 2'd0;
    endcase
  end
endmodule

// File: rtl/arb_rr_4ch.sv
// Four-requester arbiter. It supports fixed priority and round-robin modes.
// Each grant has a hold limit; when the limit is reached the grant is revoked.
//   clk      : clock, rising edge
//   rst      : synchronous reset, active high
//   bus      : request/grant bundle (slave side)
//   MAX_HOLD : most cycles a grant may stay live (2..255)
// Grant outputs are registered. Every grant change, including release,
// takes effect on the edge after the request change that causes it.
module arb_rr_4ch
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  arb_rr_4ch_if.slave bus
);
  state_e             r_state;
  logic [N_REQ-1:0]   r_grant;
  logic [ID_W-1:0]    r_gid;
  logic               r_gvalid;
  logic               r_timeout;
  logic [ID_W-1:0]    r_last;
  logic [HOLD_W-1:0]  r_hold;

  logic [ID_W-1:0]    w_rot_amt;
  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [ID_W-1:0]    w_enc_idx;
  logic               w_enc_valid;
  logic [ID_W-1:0]    w_win;
  logic               w_limit;

  // Rotate the request vector so that rotated bit k is req[(last+k) mod 4].
  // The encoder picks the highest rotated bit, which gives the search order
  // last-1, last-2, last-3, last. Fixed mode uses no rotation.
  assign w_rot_amt = bus.mode ? r_last : '0;
  assign w_dbl     = {bus.req, bus.req} >> w_rot_amt;
  assign w_rot     = w_dbl[N_REQ-1:0];

  priority_encoder_4to2 u_enc (
    .i_req   (w_rot),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  // Undo the rotation. The sum wraps mod 4 in ID_W bits.
  assign w_win = w_enc_idx + w_rot_amt;

  // In this cycle the grant has been visible for r_hold+1 cycles.
  // The sum is 9 bits wide so it cannot wrap.
  assign w_limit = ({1'b0, r_hold} + 9'd1) >= 9'(MAX_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_gid     <= '0;
      r_gvalid  <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= '0;
      r_hold    <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_enc_valid) begin
            r_state  <= ST_GRANT;
            r_grant  <= onehot(w_win);
            r_gid    <= w_win;
            r_gvalid <= 1'b1;
            r_last   <= w_win;
            r_hold   <= '0;
          end else begin
            r_grant  <= '0;
            r_gid    <= '0;
            r_gvalid <= 1'b0;
          end
        end
        ST_GRANT: begin
          // A release takes priority over the hold limit.
          if (!bus.req[r_gid]) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_gid    <= '0;
            r_gvalid <= 1'b0;
          end else if (w_limit) begin
            r_state   <= ST_RECOVER;
            r_grant   <= '0;
            r_gid     <= '0;
            r_gvalid  <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_hold <= (r_hold == '1) ? r_hold : r_hold + 1'b1;
          end
        end
        ST_RECOVER: r_state <= ST_IDLE;
        default: begin
          r_state  <= ST_IDLE;
          r_grant  <= '0;
          r_gid    <= '0;
          r_gvalid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_id    = r_gid;
  assign bus.grant_valid = r_gvalid;
  assign bus.timeout     = r_timeout;
endmodule
